// File: rtl/cfi_pkg.sv
// Shared types for the CFI violation logger: entry layout, violation kind
// and the overflow-tracking FSM encoding.
package cfi_pkg;

    localparam int CFI_PC_W  = 64;
    localparam int CFI_TS_W  = 32;
    localparam int CFI_CNT_W = 16;
    localparam int CFI_DEPTH = 4;

    typedef enum logic {
        CFI_CALL = 1'b0,
        CFI_RET  = 1'b1
    } cfi_kind_e;

    typedef struct packed {
        logic [CFI_PC_W-1:0] pc;
        cfi_kind_e           kind;
        logic [CFI_TS_W-1:0] ts;
    } cfi_log_entry_t;

    typedef enum logic {
        NORMAL   = 1'b0,
        OVERFLOW = 1'b1
    } cfi_fsm_e;

endpackage

// File: rtl/cfi_violation_logger_if.sv
// Violation input and log read port of the CFI violation logger.
// master = checker/software side, slave = the logger.
interface cfi_violation_logger_if #(
    parameter int PC_W = 64,
    parameter int TS_W = 32
);
    logic            cfi_valid;
    logic            cfi_kind;
    logic [PC_W-1:0] cfi_pc;
    logic            rd_valid;
    logic            rd_ready;
    logic [PC_W-1:0] rd_pc;
    logic            rd_kind;
    logic [TS_W-1:0] rd_ts;

    modport master (
        output cfi_valid, cfi_kind, cfi_pc, rd_ready,
        input  rd_valid, rd_pc, rd_kind, rd_ts
    );

    modport slave (
        input  cfi_valid, cfi_kind, cfi_pc, rd_ready,
        output rd_valid, rd_pc, rd_kind, rd_ts
    );
endinterface

// File: rtl/cfi_log_fifo.sv
// Generic DEPTH-entry synchronous FIFO. Pointers carry one extra wrap bit
// so full/empty fall out of a plain compare. Read data is zero when empty.
// A push into a full FIFO is only taken when a pop frees the head slot in
// the same cycle; clear has priority over push and pop.
module cfi_log_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 97
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // Next pointers and storage; clear rewinds both pointers.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q[AW-1:0]] = wdata_i;
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/cfi_violation_logger.sv
// CFI violation logger: captures violation pulses from the commit-stage
// checker into a small FIFO with a timestamp, counts accepted and dropped
// violations, and raises a level interrupt while entries are pending.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// NORMAL   | no violation has been lost since the log last went empty
// OVERFLOW | at least one violation was dropped; left once the log has
//          | drained empty with no new entry arriving
module cfi_violation_logger
    import cfi_pkg::*;
#(
    parameter int DEPTH = CFI_DEPTH,
    parameter int PC_W  = CFI_PC_W,
    parameter int TS_W  = CFI_TS_W,
    parameter int CNT_W = CFI_CNT_W
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        clear_i,
    cfi_violation_logger_if.slave       bus,
    output logic [CNT_W-1:0]            total_cnt_o,
    output logic [CNT_W-1:0]            drop_cnt_o,
    output logic                        overflow_o,
    output logic                        irq_o
);
    localparam int EW = PC_W + 1 + TS_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    cfi_fsm_e         state_q, state_d;

    logic             ev;
    logic             pop;
    logic             push;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;

    assign ev    = bus.cfi_valid & en_i & ~clear_i;
    assign pop   = ~fifo_empty & bus.rd_ready;
    assign push  = ev & (~fifo_full | pop);
    assign drop  = ev & fifo_full & ~pop;
    assign wdata = {bus.cfi_pc, bus.cfi_kind, ts_q};

    cfi_log_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.rd_valid                        = ~fifo_empty;
    assign {bus.rd_pc, bus.rd_kind, bus.rd_ts} = rdata;

    assign total_cnt_o = total_q;
    assign drop_cnt_o  = drop_q;
    assign overflow_o  = (state_q == OVERFLOW);
    assign irq_o       = ~fifo_empty & en_i;

    // Free-running timestamp and saturating counters; clear leaves ts alone.
    always_comb begin
        ts_d    = ts_q + TS_W'(1);
        total_d = total_q;
        drop_d  = drop_q;
        if (clear_i) begin
            total_d = '0;
            drop_d  = '0;
        end else begin
            if (ev && total_q != CNT_MAX) begin
                total_d = total_q + CNT_W'(1);
            end
            if (drop && drop_q != CNT_MAX) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    // Overflow tracking: enter on a drop, leave once drained with no push.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = NORMAL;
        end else begin
            case (state_q)
                NORMAL:   if (drop) state_d = OVERFLOW;
                OVERFLOW: if (fifo_empty && !push) state_d = NORMAL;
                default:  state_d = NORMAL;
            endcase
        end
    end

    // Timestamp, counter and FSM registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q    <= '0;
            total_q <= '0;
            drop_q  <= '0;
            state_q <= NORMAL;
        end else begin
            ts_q    <= ts_d;
            total_q <= total_d;
            drop_q  <= drop_d;
            state_q <= state_d;
        end
    end

endmodule
